// File: rtl/led_kernel_sched.sv
`default_nettype none
// ============================================================================
//  Module   : led_kernel_sched
//  Brief    : Round-robin scheduler sharing one start/done kernel among
//             NUM_REQ requesters, with a watchdog timeout and kernel reset
//             recovery. Each job yields a completion record tagged with
//             the requester ID.
//  Revision : 1.0 - initial release
// ============================================================================
module led_kernel_sched #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int KRST_CYCLES    = 4
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*32-1:0]   req_reg0_i,
    input  logic [NUM_REQ*32-1:0]   req_reg1_i,
    output logic                    kern_start_o,
    output logic [31:0]             kern_reg0_o,
    output logic [31:0]             kern_reg1_o,
    input  logic                    kern_done_i,
    output logic                    kern_rst_n_o,
    output logic                    cmp_valid_o,
    output logic [ID_W-1:0]         cmp_id_o,
    output logic                    cmp_err_o,
    output logic                    busy_o
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int KC_W = $clog2(KRST_CYCLES + 1);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [KC_W-1:0] KC_LAST = KC_W'(KRST_CYCLES - 1);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_KRST  = 3'd4;
    localparam logic [2:0] S_CMPL  = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [ID_W-1:0] ptr_q,   ptr_d;
    logic [ID_W-1:0] id_q,    id_d;
    logic            err_q,   err_d;
    logic [31:0]     reg0_q,  reg0_d;
    logic [31:0]     reg1_q,  reg1_d;
    logic [WD_W-1:0] wd_q,    wd_d;
    logic [KC_W-1:0] kc_q,    kc_d;

    logic            found_w;
    logic [ID_W-1:0] sel_w;

    // Arbiter: first valid requester at or after the pointer, wrapping.
    always_comb begin
        int idx;
        found_w = 1'b0;
        sel_w   = '0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found_w && req_valid_i[idx]) begin
                found_w = 1'b1;
                sel_w   = ID_W'(idx);
            end
        end
    end

    // One-hot accept, offered only while idle.
    always_comb begin
        req_ready_o = '0;
        if (state_q == S_IDLE && found_w) begin
            req_ready_o[sel_w] = 1'b1;
        end
    end

    // Next-state logic for the job sequencer, watchdog and reset counter.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        err_d   = err_q;
        reg0_d  = reg0_q;
        reg1_d  = reg1_q;
        wd_d    = wd_q;
        kc_d    = kc_q;
        case (state_q)
            S_IDLE: begin
                if (found_w) begin
                    id_d    = sel_w;
                    reg0_d  = req_reg0_i[int'(sel_w)*32 +: 32];
                    reg1_d  = req_reg1_i[int'(sel_w)*32 +: 32];
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                // Config is already on the kernel pins; give it a setup cycle.
                state_d = S_START;
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wd_q != '1) begin
                    wd_d = wd_q + 1'b1;
                end
                // Done takes precedence over a coincident timeout.
                if (kern_done_i) begin
                    err_d   = 1'b0;
                    state_d = S_CMPL;
                end else if (wd_q >= WD_LAST) begin
                    err_d   = 1'b1;
                    kc_d    = '0;
                    state_d = S_KRST;
                end
            end
            S_KRST: begin
                if (kc_q == KC_LAST) begin
                    state_d = S_CMPL;
                end else begin
                    kc_d = kc_q + 1'b1;
                end
            end
            S_CMPL: begin
                ptr_d   = (id_q == ID_LAST) ? '0 : id_q + 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any job without a completion record.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
            reg0_q  <= '0;
            reg1_q  <= '0;
            wd_q    <= '0;
            kc_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            err_q   <= err_d;
            reg0_q  <= reg0_d;
            reg1_q  <= reg1_d;
            wd_q    <= wd_d;
            kc_q    <= kc_d;
        end
    end

    assign kern_start_o = (state_q == S_START);
    assign kern_reg0_o  = reg0_q;
    assign kern_reg1_o  = reg1_q;
    assign kern_rst_n_o = (state_q != S_KRST);
    assign cmp_valid_o  = (state_q == S_CMPL);
    assign cmp_id_o     = (state_q == S_CMPL) ? id_q : '0;
    assign cmp_err_o    = (state_q == S_CMPL) & err_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/led_kernel_sched.md
Name: led_kernel_sched

Overview:
- Round-robin scheduler that shares one led_example-style kernel (start pulse in, single-cycle done out, two 32-bit config registers) among NUM_REQ requesters.
- Captures a job's reg0/reg1 words and drives the kernel's config and start.
- Waits for kernel done or a watchdog timeout, then returns a completion record tagged with the requester ID.
- Sits between the AXI-lite/bk-lite register front-ends and the kernel, so software contexts never collide on the kernel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must satisfy 2**ID_W >= NUM_REQ.
- TIMEOUT_CYCLES, 500_000_000, watchdog limit in ap_clk cycles while waiting for done (≥2).
- KRST_CYCLES, 4, length of the kernel reset pulse after a timeout (≥1).

Ports:
- ap_clk  in  1  single clock for all logic.
- ap_rst  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester job request.
- req_ready_o  out  NUM_REQ  one-hot accept; a job transfers when valid&ready.
- req_reg0_i  in  NUM_REQ*32  job reg0, requester k at bits [32k+31:32k].
- req_reg1_i  in  NUM_REQ*32  job reg1, same packing.
- kern_start_o  out  1  one-cycle start pulse to the kernel (ap_start_pedge).
- kern_reg0_o  out  32  latched reg0 for the running job.
- kern_reg1_o  out  32  latched reg1 for the running job.
- kern_done_i  in  1  kernel done pulse.
- kern_rst_n_o  out  1  active-low kernel reset, asserted only on timeout recovery.
- cmp_valid_o  out  1  one-cycle completion pulse.
- cmp_id_o  out  ID_W  requester ID of the completed job.
- cmp_err_o  out  1  1 = job ended by timeout; qualified by cmp_valid_o.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0 except kern_rst_n_o=1; state IDLE; RR pointer = 0 (requester 0 has highest priority first); watchdog = 0. Reset mid-job aborts the job silently: no completion is issued and kern_rst_n_o is not pulsed.
- FSM states: IDLE, GRANT, START, WAIT, KRST, CMPL.
  - IDLE: if any req_valid_i is set, pick the first valid requester at or after the pointer (wrapping). Drive req_ready_o one-hot for that requester this same cycle (combinational from registered state and req_valid_i). Capture its reg0/reg1 and ID, then go to GRANT. With no valid requests, stay in IDLE and hold req_ready_o=0.
  - GRANT: kern_reg0_o/kern_reg1_o are stable from this cycle. Go to START. This gives the kernel's input register stage one cycle of setup before start.
  - START: kern_start_o=1 for exactly one cycle; clear the watchdog; go to WAIT.
  - WAIT: increment the watchdog every cycle.
    - kern_done_i=1: go to CMPL with err=0.
    - Watchdog reaches TIMEOUT_CYCLES-1 with no done: go to KRST with err=1.
    - Done and timeout in the same cycle: done wins, err=0.
  - KRST: drive kern_rst_n_o=0 for KRST_CYCLES cycles, then go to CMPL.
  - CMPL: cmp_valid_o=1 for one cycle, with cmp_id_o and cmp_err_o stable. Set the pointer to granted ID+1, wrapping to 0 past NUM_REQ-1. Go to IDLE.
- Throughput: at most one job in flight. Minimum cycle from accept to the next accept is 4 + kernel latency.
- kern_done_i outside WAIT is ignored. This covers a stale done after timeout or a done in START.
- kern_reg0_o/kern_reg1_o hold the last job's values until the next capture; they are not cleared in IDLE.
- A requester may drop req_valid_i before it is granted, with no effect. Its data must be stable while valid is high.
- Watchdog width is $clog2(TIMEOUT_CYCLES)+1 bits and saturates; it cannot wrap.

Test Plan:
- Single job: requester 2 asserts valid with reg0=0x1, reg1=0x0; kernel model returns done 10 cycles after start. Required: ready[2] for 1 cycle; kern_start_o 2 cycles later; kern_reg0_o=0x1; cmp_valid_o with cmp_id_o=2, cmp_err_o=0 one cycle after done.
- Round-robin fairness: all 4 requesters hold valid with distinct reg0 values for 8 jobs. Required grant order 0,1,2,3,0,1,2,3, with each kern_reg0_o matching its requester.
- Timeout: TIMEOUT_CYCLES=20, KRST_CYCLES=4, kernel never returns done. Required: kern_rst_n_o low for exactly 4 cycles, then cmp_valid_o with cmp_err_o=1. A late kern_done_i injected afterwards is ignored.
- Done and timeout coincide: done arrives on the watchdog's final cycle. Required: cmp_err_o=0 and no kern_rst_n_o pulse.
- Reset mid-WAIT: assert ap_rst for 1 cycle during WAIT. Required: busy_o=0 and no cmp_valid_o; the next request from requester 3 is granted before requester 0 only if 0 is not valid, since the pointer is back at 0.
